// File: rtl/dmem_if.sv
// dmem_if: load/store request-acknowledge bus between a requester and the data memory
interface dmem_if;
    logic        req;
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        ack;
    logic [31:0] rdata;
    logic        err;
    logic        busy;
    modport master (output req, we, addr, wdata, input ack, rdata, err, busy);
    modport slave  (input req, we, addr, wdata, output ack, rdata, err, busy);
endinterface

// File: rtl/dmem_responder.sv
// dmem_responder: word-addressed data memory answering requests after WAIT_CYCLES wait states
module dmem_responder #(
    parameter int DEPTH_WORDS = 64,
    parameter int WAIT_CYCLES = 2
) (
    input  logic   clk,
    input  logic   rst,
    dmem_if.slave  bus
);
    localparam int AW = $clog2(DEPTH_WORDS);
    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;
    state_t      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [31:0] addr_q, addr_d, wdata_q, wdata_d, rdata_q, rdata_d;
    logic        we_q, we_d, ack_q, ack_d, err_q, err_d, busy_q, busy_d;
    logic [31:0] mem_q [DEPTH_WORDS];
    logic [31:0] a, wd;
    logic        w, capture, go, fault, wr;
    logic [AW-1:0] idx;
    always_comb begin
        // with zero wait states capture and RESP entry share an edge, so use the live payload
        a       = state_q == IDLE ? bus.addr  : addr_q;
        wd      = state_q == IDLE ? bus.wdata : wdata_q;
        w       = state_q == IDLE ? bus.we    : we_q;
        idx     = a[AW+1:2];
        fault   = a[1:0] != 2'b00 || a[31:2] >= 30'(DEPTH_WORDS);
        capture = state_q == IDLE && bus.req;
        go      = (capture && WAIT_CYCLES == 0) || (state_q == WAIT && cnt_q == 4'd1);
        wr      = go && w && !fault;
        addr_d  = capture ? bus.addr  : addr_q;
        wdata_d = capture ? bus.wdata : wdata_q;
        we_d    = capture ? bus.we    : we_q;
        cnt_d   = capture ? 4'(WAIT_CYCLES) : state_q == WAIT ? cnt_q - 4'd1 : cnt_q;
        state_d = state_q == RESP ? IDLE : go ? RESP : capture ? WAIT : state_q;
        rdata_d = go ? ((w || fault) ? '0 : mem_q[idx]) : rdata_q;
        err_d   = go ? fault : err_q;
        ack_d   = state_d == RESP;
        busy_d  = state_d != IDLE;
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            addr_q  <= '0;
            wdata_q <= '0;
            we_q    <= 1'b0;
            rdata_q <= '0;
            err_q   <= 1'b0;
            ack_q   <= 1'b0;
            busy_q  <= 1'b0;
            for (int i = 0; i < DEPTH_WORDS; i++) mem_q[i] <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            we_q    <= we_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
            ack_q   <= ack_d;
            busy_q  <= busy_d;
            if (wr) mem_q[idx] <= wd;
        end
    end
    assign bus.ack   = ack_q;
    assign bus.rdata = rdata_q;
    assign bus.err   = err_q;
    assign bus.busy  = busy_q;
endmodule

// File: tb/tb_dmem_responder.sv
// tb_dmem_responder: randomized and directed checks of dmem_responder against a memory model
module tb_dmem_responder;
    localparam int DW = 64;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int checks = 0;
    int failures = 0;
    logic [31:0] m2 [DW];
    logic [31:0] m0 [DW];
    always #5 clk = ~clk;
    dmem_if i2 ();
    dmem_if i0 ();
    dmem_responder #(.DEPTH_WORDS(DW), .WAIT_CYCLES(2)) u2 (.clk(clk), .rst(rst), .bus(i2.slave));
    dmem_responder #(.DEPTH_WORDS(DW), .WAIT_CYCLES(0)) u0 (.clk(clk), .rst(rst), .bus(i0.slave));

    function automatic void ref_acc(input bit z, input logic w, input logic [31:0] a, input logic [31:0] wd,
                                    output logic [31:0] rd, output logic e);
        e  = a[1:0] != 2'b00 || a[31:2] >= 30'(DW);
        rd = '0;
        if (!e && w) begin
            if (z) m0[a[7:2]] = wd;
            else m2[a[7:2]] = wd;
        end
        if (!e && !w) rd = z ? m0[a[7:2]] : m2[a[7:2]];
    endfunction

    function automatic void ref_clear();
        for (int i = 0; i < DW; i++) begin
            m2[i] = '0;
            m0[i] = '0;
        end
    endfunction

    task automatic xact2(input logic w, input logic [31:0] a, input logic [31:0] wd,
                         output int lat, output logic [31:0] rd, output logic e, output logic bz);
        i2.req = 1'b1; i2.we = w; i2.addr = a; i2.wdata = wd;
        lat = -1;
        for (int n = 0; n < 20; n++) begin
            @(posedge clk); #1;
            if (i2.ack) begin lat = n; break; end
        end
        rd = i2.rdata; e = i2.err; bz = i2.busy;
        i2.req = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_reset();
        #1;
        checks++; if (i2.ack !== 1'b0) begin failures++; $display("FAIL rst_ack got=%b exp=0", i2.ack); end
        checks++; if (i2.busy !== 1'b0) begin failures++; $display("FAIL rst_busy got=%b exp=0", i2.busy); end
        checks++; if (i2.err !== 1'b0) begin failures++; $display("FAIL rst_err got=%b exp=0", i2.err); end
        checks++; if (i2.rdata !== 32'h0) begin failures++; $display("FAIL rst_rdata got=%h exp=0", i2.rdata); end
        checks++; if (i0.ack !== 1'b0 || i0.busy !== 1'b0) begin failures++; $display("FAIL rst_w0 got=%b%b exp=00", i0.ack, i0.busy); end
        @(posedge clk); #1;
        rst = 1'b0;
    endtask

    task automatic test_store_load();
        int lat; logic [31:0] rd, erd; logic e, ee, bz;
        ref_acc(0, 1'b1, 32'h10, 32'hDEADBEEF, erd, ee);
        xact2(1'b1, 32'h10, 32'hDEADBEEF, lat, rd, e, bz);
        checks++; if (lat !== 2) begin failures++; $display("FAIL st_lat got=%0d exp=2", lat); end
        checks++; if (e !== ee || rd !== erd) begin failures++; $display("FAIL st_resp got=%b/%h exp=%b/%h", e, rd, ee, erd); end
        checks++; if (bz !== 1'b1) begin failures++; $display("FAIL st_busy_ack got=%b exp=1", bz); end
        checks++; if (i2.ack !== 1'b0 || i2.busy !== 1'b0) begin failures++; $display("FAIL st_drop got=%b%b exp=00", i2.ack, i2.busy); end
        ref_acc(0, 1'b0, 32'h10, 32'h0, erd, ee);
        xact2(1'b0, 32'h10, 32'h0, lat, rd, e, bz);
        checks++; if (lat !== 2) begin failures++; $display("FAIL ld_lat got=%0d exp=2", lat); end
        checks++; if (rd !== erd || e !== ee) begin failures++; $display("FAIL ld_data got=%h/%b exp=%h/%b", rd, e, erd, ee); end
        checks++; if (i2.rdata !== erd) begin failures++; $display("FAIL ld_hold got=%h exp=%h", i2.rdata, erd); end
    endtask

    task automatic test_zero_wait();
        logic [31:0] erd, wv; logic ee, pw;
        wv = $urandom;
        pw = 1'b1;
        i0.req = 1'b1; i0.we = 1'b1; i0.addr = 32'h4; i0.wdata = 32'h12345678;
        ref_acc(1, 1'b1, 32'h4, 32'h12345678, erd, ee);
        for (int c = 0; c < 8; c++) begin
            @(posedge clk); #1;
            checks++; if (i0.ack !== (c % 2 == 0)) begin failures++; $display("FAIL zw_ack c=%0d got=%b exp=%b", c, i0.ack, c % 2 == 0); end
            if (i0.ack) begin
                checks++; if (i0.rdata !== erd || i0.err !== ee) begin failures++; $display("FAIL zw_data c=%0d got=%h/%b exp=%h/%b", c, i0.rdata, i0.err, erd, ee); end
                pw = !pw;
                i0.we = pw; i0.wdata = wv;
                ref_acc(1, pw, 32'h4, wv, erd, ee);
            end
        end
        i0.req = 1'b0;
        @(posedge clk); #1;
        checks++; if (i0.busy !== 1'b0) begin failures++; $display("FAIL zw_idle got=%b exp=0", i0.busy); end
    endtask

    task automatic test_faults();
        int lat; logic [31:0] rd, erd; logic e, ee, bz;
        ref_acc(0, 1'b1, 32'h0, 32'h0BADF00D, erd, ee);
        xact2(1'b1, 32'h0, 32'h0BADF00D, lat, rd, e, bz);
        xact2(1'b0, 32'h6, 32'h0, lat, rd, e, bz);
        checks++; if (e !== 1'b1 || rd !== 32'h0 || lat !== 2) begin failures++; $display("FAIL f_misalign got=%b/%h/%0d exp=1/0/2", e, rd, lat); end
        xact2(1'b1, 32'h100, 32'hFFFFFFFF, lat, rd, e, bz);
        checks++; if (e !== 1'b1 || rd !== 32'h0) begin failures++; $display("FAIL f_range got=%b/%h exp=1/0", e, rd); end
        ref_acc(0, 1'b0, 32'h0, 32'h0, erd, ee);
        xact2(1'b0, 32'h0, 32'h0, lat, rd, e, bz);
        checks++; if (rd !== erd || e !== ee) begin failures++; $display("FAIL f_nowrite got=%h/%b exp=%h/%b", rd, e, erd, ee); end
    endtask

    task automatic test_payload_ignored();
        int lat; logic [31:0] rd, erd; logic e, ee, bz;
        ref_acc(0, 1'b1, 32'h30, 32'h77777777, erd, ee);
        i2.req = 1'b1; i2.we = 1'b1; i2.addr = 32'h30; i2.wdata = 32'h77777777;
        @(posedge clk); #1;
        i2.addr = 32'h34; i2.wdata = 32'h88888888; i2.we = 1'b0;
        lat = -1;
        for (int n = 1; n < 20; n++) begin
            @(posedge clk); #1;
            if (i2.ack) begin lat = n; break; end
        end
        checks++; if (lat !== 2 || i2.rdata !== 32'h0) begin failures++; $display("FAIL pi_resp got=%0d/%h exp=2/0", lat, i2.rdata); end
        i2.req = 1'b0;
        @(posedge clk); #1;
        ref_acc(0, 1'b0, 32'h30, 32'h0, erd, ee);
        xact2(1'b0, 32'h30, 32'h0, lat, rd, e, bz);
        checks++; if (rd !== erd) begin failures++; $display("FAIL pi_old got=%h exp=%h", rd, erd); end
        ref_acc(0, 1'b0, 32'h34, 32'h0, erd, ee);
        xact2(1'b0, 32'h34, 32'h0, lat, rd, e, bz);
        checks++; if (rd !== erd) begin failures++; $display("FAIL pi_new got=%h exp=%h", rd, erd); end
    endtask

    task automatic test_boundary();
        int lat; logic [31:0] rd, erd; logic e, ee, bz;
        ref_acc(0, 1'b1, 32'hFC, 32'hA5A5A5A5, erd, ee);
        xact2(1'b1, 32'hFC, 32'hA5A5A5A5, lat, rd, e, bz);
        checks++; if (e !== ee) begin failures++; $display("FAIL bd_err got=%b exp=%b", e, ee); end
        ref_acc(0, 1'b0, 32'hFC, 32'h0, erd, ee);
        xact2(1'b0, 32'hFC, 32'h0, lat, rd, e, bz);
        checks++; if (rd !== erd || e !== ee) begin failures++; $display("FAIL bd_read got=%h/%b exp=%h/%b", rd, e, erd, ee); end
    endtask

    task automatic test_random();
        int lat; logic [31:0] a, wd, rd, erd; logic w, e, ee, bz;
        for (int k = 0; k < 40; k++) begin
            w  = 1'($urandom_range(0, 1));
            a  = $urandom_range(0, 32'h10F);
            if ($urandom_range(0, 3) != 0) a[1:0] = 2'b00;
            wd = $urandom;
            ref_acc(0, w, a, wd, erd, ee);
            xact2(w, a, wd, lat, rd, e, bz);
            checks++; if (lat !== 2 || rd !== erd || e !== ee) begin failures++; $display("FAIL rnd k=%0d a=%h we=%b got=%0d/%h/%b exp=2/%h/%b", k, a, w, lat, rd, e, erd, ee); end
        end
    endtask

    task automatic test_reset_mid();
        int lat; logic [31:0] rd; logic e, bz;
        xact2(1'b0, 32'h6, 32'h0, lat, rd, e, bz);
        i2.req = 1'b1; i2.we = 1'b1; i2.addr = 32'h20; i2.wdata = 32'h11111111;
        @(posedge clk); #1;
        @(posedge clk); #1;
        checks++; if (i2.busy !== 1'b1 || i2.err !== 1'b1) begin failures++; $display("FAIL rm_pre got=%b/%b exp=1/1", i2.busy, i2.err); end
        rst = 1'b1;
        #1;
        checks++; if (i2.ack !== 1'b0 || i2.busy !== 1'b0 || i2.err !== 1'b0 || i2.rdata !== 32'h0) begin
            failures++; $display("FAIL rm_async got=%b%b%b/%h exp=000/0", i2.ack, i2.busy, i2.err, i2.rdata); end
        ref_clear();
        i2.we = 1'b0;
        @(posedge clk); #1;
        checks++; if (i2.ack !== 1'b0) begin failures++; $display("FAIL rm_noack got=%b exp=0", i2.ack); end
        rst = 1'b0;
        lat = -1;
        for (int n = 0; n < 20; n++) begin
            @(posedge clk); #1;
            if (i2.ack) begin lat = n; break; end
        end
        checks++; if (lat !== 2 || i2.rdata !== m2[8]) begin failures++; $display("FAIL rm_discard got=%0d/%h exp=2/%h", lat, i2.rdata, m2[8]); end
        i2.req = 1'b0;
        @(posedge clk); #1;
        xact2(1'b0, 32'h0, 32'h0, lat, rd, e, bz);
        checks++; if (rd !== m2[0] || e !== 1'b0) begin failures++; $display("FAIL rm_clear got=%h/%b exp=%h/0", rd, e, m2[0]); end
    endtask

    initial begin
        i2.req = 1'b0; i2.we = 1'b0; i2.addr = '0; i2.wdata = '0;
        i0.req = 1'b0; i0.we = 1'b0; i0.addr = '0; i0.wdata = '0;
        ref_clear();
        test_reset();
        test_store_load();
        test_zero_wait();
        test_faults();
        test_payload_ignored();
        test_boundary();
        test_random();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end
endmodule
